noc_input_vc_unit: RTL

- Input stage of one router port, directly upstream of the per-output-port controller.
- Buffers incoming flits in one FIFO per virtual channel and computes an XY route from each head flit.
- Drives the start-of-packet / request / end-of-packet / free bundle toward the selected output port, pops flits on grant, and returns credits upstream.
- Each router instantiates five of these, one per input direction.

---
 rtl/noc_input_vc_unit_pkg.sv | 46 ++++
 rtl/noc_input_vc_unit_fifo.sv | 45 ++++
 rtl/noc_input_vc_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/noc_input_vc_unit_pkg.sv
// Shared types and helpers for the router input-port VC unit.
// Flit type encoding, port indices and the XY route function.
package noc_input_vc_unit_pkg;

    localparam int NOC_VC_CHANNEL = 2;
    localparam int NUM_PORTS      = 5;
    localparam int COORD_MAX_W    = 16;

    localparam int LOCAL = 0;
    localparam int EAST  = 1;
    localparam int WEST  = 2;
    localparam int NORTH = 3;
    localparam int SOUTH = 4;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_e;

    typedef struct packed {
        logic [COORD_MAX_W-1:0] x;
        logic [COORD_MAX_W-1:0] y;
    } coord_t;

    function automatic logic [NUM_PORTS-1:0] route_xy(
        input coord_t cur,
        input coord_t dest
    );
        logic [NUM_PORTS-1:0] r;
        r = '0;
        if (dest.x > cur.x)      r[EAST]  = 1'b1;
        else if (dest.x < cur.x) r[WEST]  = 1'b1;
        else if (dest.y > cur.y) r[NORTH] = 1'b1;
        else if (dest.y < cur.y) r[SOUTH] = 1'b1;
        else                     r[LOCAL] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/noc_input_vc_unit_fifo.sv
// Per-VC flit FIFO with a combinational front word.
// The caller only pushes when there is room and only pops when non-empty.
module noc_vc_fifo
    import noc_input_vc_unit_pkg::*;
#(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [FLIT_W-1:0] din,
    output logic [FLIT_W-1:0] front,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign front = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/noc_input_vc_unit.sv
// Router input port: per-VC flit buffering, XY routing, grant-driven pops
// toward the crossbar and upstream credit return.
module noc_input_vc_unit
    import noc_input_vc_unit_pkg::*;
#(
    parameter int  CHANNELS = NOC_VC_CHANNEL,
    parameter int  FLIT_W   = 32,
    parameter int  DEPTH    = 4,
    parameter int  COORD_W  = 4,
    localparam int VCW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                               noc_clk,
    input  logic                               noc_rst,
    input  logic [COORD_W-1:0]                 cur_x,
    input  logic [COORD_W-1:0]                 cur_y,
    input  logic                               flit_valid_i,
    input  logic [VCW-1:0]                     flit_vc_i,
    input  logic [FLIT_W-1:0]                  flit_i,
    output logic [CHANNELS-1:0]                credit_o,
    output logic [NUM_PORTS-1:0][CHANNELS-1:0] sop_o,
    output logic [NUM_PORTS-1:0][CHANNELS-1:0] req_o,
    output logic [NUM_PORTS-1:0][CHANNELS-1:0] eop_o,
    output logic [NUM_PORTS-1:0][CHANNELS-1:0] free_o,
    input  logic [NUM_PORTS-1:0][CHANNELS-1:0] grant_i,
    output logic                               flit_valid_o,
    output logic [FLIT_W-1:0]                  flit_o,
    output logic [NUM_PORTS-1:0]               out_port_o,
    output logic                               err_o
);

    logic [CHANNELS-1:0]  empty, full, push, pop, hit, win;
    logic [FLIT_W-1:0]    front   [CHANNELS];
    vc_state_e            state_q [CHANNELS];
    vc_state_e            state_d [CHANNELS];
    logic [NUM_PORTS-1:0] route_q [CHANNELS];
    logic [NUM_PORTS-1:0] route_d [CHANNELS];
    logic                 err_d;
    logic [FLIT_W-1:0]    win_flit;
    logic [NUM_PORTS-1:0] win_port;

    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        noc_vc_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
            .clk   (noc_clk),
            .rst   (noc_rst),
            .push  (push[v]),
            .pop   (pop[v]),
            .din   (flit_i),
            .front (front[v]),
            .empty (empty[v]),
            .full  (full[v])
        );
    end

    always_comb begin
        logic                 taken, arrive, lead, last, in_lead;
        logic [NUM_PORTS-1:0] gcol, rt;
        coord_t               here, dest;
        push = '0; pop = '0; hit = '0; win = '0;
        err_d = 1'b0; win_flit = '0; win_port = '0;
        credit_o = '0; sop_o = '0; req_o = '0; eop_o = '0; free_o = '0;
        taken = 1'b0; arrive = 1'b0; lead = 1'b0; last = 1'b0;
        in_lead = 1'b0; gcol = '0; rt = '0; dest = '0;
        here.x = COORD_MAX_W'(cur_x);
        here.y = COORD_MAX_W'(cur_y);
        for (int v = 0; v < CHANNELS; v++) begin
            state_d[v] = state_q[v];
            route_d[v] = route_q[v];
        end
        // A grant counts only on the latched route of an active, non-empty VC
        for (int v = 0; v < CHANNELS; v++) begin
            for (int p = 0; p < NUM_PORTS; p++) gcol[p] = grant_i[p][v];
            hit[v] = !noc_rst && state_q[v] == VC_ACTIVE && !empty[v] &&
                     |(gcol & route_q[v]);
            if (|gcol && !hit[v]) err_d = 1'b1;
        end
        for (int v = 0; v < CHANNELS; v++) begin
            if (hit[v]) begin
                if (!taken) begin
                    win[v] = 1'b1;
                    taken  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        for (int v = 0; v < CHANNELS; v++) begin
            arrive  = flit_valid_i && flit_vc_i == VCW'(v);
            lead    = front[v][FLIT_W-1 -: 2] == HEAD ||
                      front[v][FLIT_W-1 -: 2] == SINGLE;
            last    = front[v][FLIT_W-1 -: 2] == TAIL ||
                      front[v][FLIT_W-1 -: 2] == SINGLE;
            in_lead = flit_i[FLIT_W-1 -: 2] == HEAD ||
                      flit_i[FLIT_W-1 -: 2] == SINGLE;
            // Empty VC routes from the arriving head so ACTIVE is reached on its push edge
            if (empty[v]) begin
                dest.x = COORD_MAX_W'(flit_i[2*COORD_W-1:COORD_W]);
                dest.y = COORD_MAX_W'(flit_i[COORD_W-1:0]);
            end else begin
                dest.x = COORD_MAX_W'(front[v][2*COORD_W-1:COORD_W]);
                dest.y = COORD_MAX_W'(front[v][COORD_W-1:0]);
            end
            rt = route_xy(here, dest);
            unique case (state_q[v])
                VC_IDLE: begin
                    if (!empty[v]) begin
                        if (lead) begin
                            state_d[v] = VC_ACTIVE;
                            route_d[v] = rt;
                        end else if (!noc_rst) begin
                            pop[v] = 1'b1;
                            err_d  = 1'b1;
                        end
                    end else if (arrive && in_lead) begin
                        state_d[v] = VC_ACTIVE;
                        route_d[v] = rt;
                    end
                end
                VC_ACTIVE: begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        sop_o[p][v] = route_q[v][p];
                        req_o[p][v] = route_q[v][p] && !empty[v];
                    end
                    if (win[v]) begin
                        pop[v] = 1'b1;
                        if (last) begin
                            state_d[v] = VC_IDLE;
                            for (int p = 0; p < NUM_PORTS; p++) begin
                                eop_o[p][v]  = route_q[v][p];
                                free_o[p][v] = route_q[v][p];
                            end
                        end
                    end
                end
                default: ;
            endcase
            credit_o[v] = pop[v];
            push[v] = !noc_rst && arrive && (!full[v] || pop[v]);
            if (arrive && full[v] && !pop[v]) err_d = 1'b1;
            if (win[v]) begin
                win_flit = front[v];
                win_port = route_q[v];
            end
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            for (int v = 0; v < CHANNELS; v++) begin
                state_q[v] <= VC_IDLE;
                route_q[v] <= '0;
            end
            err_o        <= 1'b0;
            flit_valid_o <= 1'b0;
            flit_o       <= '0;
            out_port_o   <= '0;
        end else begin
            for (int v = 0; v < CHANNELS; v++) begin
                state_q[v] <= state_d[v];
                route_q[v] <= route_d[v];
            end
            err_o        <= err_o | err_d;
            flit_valid_o <= |win;
            if (|win) begin
                flit_o     <= win_flit;
                out_port_o <= win_port;
            end
        end
    end

endmodule
